// File: rtl/cordic_iteration.sv
// Single combinational CORDIC micro-rotation: one shift-add step on x/y and one
// angle-table update on z. Modes are circular, linear and hyperbolic.
module cordic_iteration #(
    parameter int unsigned FIXED_WIDTH = 16
) (
    input  logic signed [FIXED_WIDTH-1:0] x,
    input  logic signed [FIXED_WIDTH-1:0] y,
    input  logic signed [FIXED_WIDTH-1:0] z,
    input  logic        [1:0]             mode,
    input  logic                          is_sigma_positive,
    input  logic        [3:0]             shift,
    input  logic signed [FIXED_WIDTH-1:0] delta_z,
    output logic signed [FIXED_WIDTH-1:0] next_x,
    output logic signed [FIXED_WIDTH-1:0] next_y,
    output logic signed [FIXED_WIDTH-1:0] next_z
);

    logic signed [FIXED_WIDTH-1:0] x_sh;
    logic signed [FIXED_WIDTH-1:0] y_sh;

    always_comb begin
        x_sh   = x >>> shift;
        y_sh   = y >>> shift;
        next_y = is_sigma_positive ? y + x_sh : y - x_sh;
        next_z = is_sigma_positive ? z - delta_z : z + delta_z;
        case (mode)
            2'b00:   next_x = is_sigma_positive ? x - y_sh : x + y_sh;
            2'b10:   next_x = is_sigma_positive ? x + y_sh : x - y_sh;
            default: next_x = x;
        endcase
    end

endmodule

// File: rtl/cordic_controller.sv
// Iterative multi-mode CORDIC engine: loads operands on start, runs one
// micro-rotation per clock for ITERATIONS cycles, then presents the results.
module cordic_controller #(
    parameter int unsigned FIXED_WIDTH = 16,
    parameter int unsigned ITERATIONS  = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic        [1:0]             mode,
    input  logic                          vectoring,
    input  logic signed [FIXED_WIDTH-1:0] x_in,
    input  logic signed [FIXED_WIDTH-1:0] y_in,
    input  logic signed [FIXED_WIDTH-1:0] z_in,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic signed [FIXED_WIDTH-1:0] x_out,
    output logic signed [FIXED_WIDTH-1:0] y_out,
    output logic signed [FIXED_WIDTH-1:0] z_out
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [1:0] ModeCirc    = 2'b00;
    localparam logic [1:0] ModeLin     = 2'b01;
    localparam logic [1:0] ModeHyp     = 2'b10;
    localparam logic [1:0] ModeInvalid = 2'b11;
    localparam logic [3:0] LastStep    = 4'(ITERATIONS - 1);
    localparam logic signed [FIXED_WIDTH-1:0] One = FIXED_WIDTH'(4096);

    state_e                        state_q;
    logic        [3:0]             step_q;
    logic        [3:0]             shift;
    logic        [1:0]             mode_q;
    logic                          vec_q;
    logic signed [FIXED_WIDTH-1:0] x_q, y_q, z_q;
    logic signed [FIXED_WIDTH-1:0] delta_z;
    logic signed [FIXED_WIDTH-1:0] next_x, next_y, next_z;
    logic                          is_sigma_positive;

    assign is_sigma_positive = vec_q ? y_q[FIXED_WIDTH-1] : ~z_q[FIXED_WIDTH-1];

    always_comb begin
        shift   = step_q;
        delta_z = '0;
        case (mode_q)
            ModeCirc: begin
                case (step_q)
                    4'd0:    delta_z = FIXED_WIDTH'(3217);
                    4'd1:    delta_z = FIXED_WIDTH'(1899);
                    4'd2:    delta_z = FIXED_WIDTH'(1003);
                    4'd3:    delta_z = FIXED_WIDTH'(509);
                    4'd4:    delta_z = FIXED_WIDTH'(256);
                    4'd5:    delta_z = FIXED_WIDTH'(128);
                    4'd6:    delta_z = FIXED_WIDTH'(64);
                    4'd7:    delta_z = FIXED_WIDTH'(32);
                    4'd8:    delta_z = FIXED_WIDTH'(16);
                    default: delta_z = '0;
                endcase
            end
            ModeLin: delta_z = One >>> shift;
            ModeHyp: begin
                // Schedule starts at 1 and repeats 4 so the hyperbolic sequence converges.
                shift = (step_q < 4'd4) ? step_q + 4'd1 : step_q;
                case (shift)
                    4'd1:    delta_z = FIXED_WIDTH'(2250);
                    4'd2:    delta_z = FIXED_WIDTH'(1046);
                    4'd3:    delta_z = FIXED_WIDTH'(515);
                    4'd4:    delta_z = FIXED_WIDTH'(256);
                    4'd5:    delta_z = FIXED_WIDTH'(128);
                    4'd6:    delta_z = FIXED_WIDTH'(64);
                    4'd7:    delta_z = FIXED_WIDTH'(32);
                    4'd8:    delta_z = FIXED_WIDTH'(16);
                    default: delta_z = '0;
                endcase
            end
            default: delta_z = '0;
        endcase
    end

    cordic_iteration #(
        .FIXED_WIDTH(FIXED_WIDTH)
    ) u_iter (
        .x                 (x_q),
        .y                 (y_q),
        .z                 (z_q),
        .mode              (mode_q),
        .is_sigma_positive (is_sigma_positive),
        .shift             (shift),
        .delta_z           (delta_z),
        .next_x            (next_x),
        .next_y            (next_y),
        .next_z            (next_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            mode_q  <= ModeCirc;
            vec_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            x_out   <= '0;
            y_out   <= '0;
            z_out   <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    x_q    <= next_x;
                    y_q    <= next_y;
                    z_q    <= next_z;
                    step_q <= step_q + 4'd1;
                    if (step_q == LastStep) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        x_out   <= next_x;
                        y_out   <= next_y;
                        z_out   <= next_z;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                    if (start) begin
                        err <= 1'b0;
                        if (mode == ModeInvalid) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            x_out   <= '0;
                            y_out   <= '0;
                            z_out   <= '0;
                        end else begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                            x_q     <= x_in;
                            y_q     <= y_in;
                            z_q     <= z_in;
                            mode_q  <= mode;
                            vec_q   <= vectoring;
                            step_q  <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/cordic_controller.md
CORDIC_CONTROLLER -- requirements
Module: cordic_controller

Interface
REQ-001 SHALL have parameter FIXED_WIDTH, default 16, the data width of x/y/z in signed Q4.12 (1.0 = 4096).
REQ-002 SHALL have parameter ITERATIONS, default 9, the number of datapath steps per operation.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin an operation.
REQ-006 SHALL have port mode, input, 2, where 00 = circular, 01 = linear, 10 = hyperbolic and 11 = invalid.
REQ-007 SHALL have port vectoring, input, 1, where 0 = rotation (sigma = z>=0) and 1 = vectoring (sigma = y<0).
REQ-008 SHALL have ports x_in, y_in and z_in, inputs, FIXED_WIDTH each, the signed operands sampled with start.
REQ-009 SHALL have port busy, output, 1, high while iterating.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking valid results.
REQ-011 SHALL have port err, output, 1, high with done when the operation used mode 11.
REQ-012 SHALL have ports x_out, y_out and z_out, outputs, FIXED_WIDTH each, holding the results of the last operation.

Function
REQ-013 SHALL instantiate CORDIC_iteration once, drive it combinationally from its internal x/y/z registers, and register next_x/y/z each RUN cycle.
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 SHALL accept start in IDLE or DONE: load x/y/z, latch mode and vectoring, clear the step counter, enter RUN and drop the done pulse.
REQ-016 SHALL ignore start in RUN (no restart, no queuing).
REQ-017 SHALL, in RUN, perform one iteration per clock for exactly ITERATIONS cycles, then enter DONE.
REQ-018 SHALL, on the edge entering DONE, copy x/y/z to x_out/y_out/z_out and assert done for exactly one cycle.
REQ-019 SHALL go from DONE to IDLE on the following edge unless start is high.
REQ-020 SHALL keep busy high for the exact ITERATIONS cycles of RUN, give done a latency of ITERATIONS+1 edges after the start edge (10 at default), and never assert busy and done together.
REQ-021 SHALL use shift schedule i = 0..8 for circular and linear.
REQ-022 SHALL use shift schedule i = 1,2,3,4,4,5,6,7,8 for hyperbolic, repeating i=4 for convergence; all modes therefore take 9 steps.
REQ-023 SHALL use delta_z for circular = atan(2^-i) table 3217,1899,1003,509,256,128,64,32,16.
REQ-024 SHALL use delta_z for hyperbolic = atanh(2^-i) for i = 1..8: 2250,1046,515,256,128,64,32,16.
REQ-025 SHALL use delta_z for linear = 4096>>i.
REQ-026 SHALL evaluate sigma each RUN cycle from the current registers: rotation gives is_sigma_positive = (z >= 0); vectoring gives is_sigma_positive = (y < 0).
REQ-027 SHALL apply no gain compensation; the caller pre-scales x (circular 1/K ~ 2487, hyperbolic 1/Kh ~ 4946).
REQ-028 SHALL use two's-complement wrap-around arithmetic with no saturation and no overflow flag.
REQ-029 SHALL, when a start has mode 11, skip RUN, go directly to DONE on the next edge, set x_out/y_out/z_out to 0, and assert err and done together for one cycle.
REQ-030 SHALL clear err on the next accepted start.
REQ-031 SHALL leave x_out/y_out/z_out unchanged during RUN; they update only on entry to DONE.

Reset
REQ-032 SHALL, when rst is high at a clock edge, set state IDLE, busy 0, done 0, err 0, x_out/y_out/z_out 0, step counter 0 and internal x/y/z 0.
REQ-033 SHALL abort an in-progress RUN on reset with no done pulse; rst has priority over start in the same cycle.

Verification
REQ-034 SHALL pass circular rotation: x=2487, y=0, z=2145 (pi/6) -> done at edge 10 with x_out=3547+/-8, y_out=2048+/-8, z_out within +/-16 of 0, and busy high for 9 cycles.
REQ-035 SHALL pass linear: rotation x=2048, y=0, z=6144 -> y_out=3072+/-16; vectoring x=4096, y=2048, z=0 -> z_out=2048+/-16 and y_out within +/-16 of 0.
REQ-036 SHALL pass hyperbolic rotation: x=4946, y=0, z=2048 -> x_out=4619+/-16, y_out=2134+/-16, with the shift sequence observed as 1,2,3,4,4,5,6,7,8.
REQ-037 SHALL pass mode 11 start -> done and err both high at edge 1 with outputs 0; a following valid start clears err.
REQ-038 SHALL pass back-to-back: a start pulse during RUN cycle 4 is ignored (single done); a start in the DONE cycle begins a new operation with done 10 edges later.
REQ-039 SHALL pass mid-run reset: rst asserted in RUN cycle 5 -> next cycle IDLE, busy 0, no done, outputs 0.
